// File: rtl/shifter_pkg.sv
// Shared constants and amount-decode helper for the datapath left shifter.
// Default widths match the processor datapath; the top module may be re-parameterised.
package shifter_pkg;

    localparam int SHIFTER_DATA_W = 16;
    localparam int SHIFTER_AMT_W  = 8;
    localparam int SHIFTER_STAGES = $clog2(SHIFTER_DATA_W);

    // True when any amount bit above the barrel-stage select bits is set,
    // i.e. the shift distance is at least 2**stages and the result must be zero.
    function automatic logic amount_out_of_range(input logic [31:0] amount,
                                                 input int unsigned stages);
        return (amount >> stages) != 32'd0;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One level of the logarithmic barrel shifter: optional fixed left shift by DIST.
module shifter_stage #(
    parameter int DATA_W = 16,
    parameter int DIST   = 1
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] result
);

    assign result = sel ? {operand[DATA_W-1-DIST:0], {DIST{1'b0}}} : operand;

endmodule

// File: rtl/shifter.sv
// Registered logical left barrel shifter with out-of-range zeroing and a valid flag.
// One cycle of latency, accepts a new operation every cycle.
module shifter
    import shifter_pkg::*;
#(
    parameter int DATA_W = SHIFTER_DATA_W,
    parameter int AMT_W  = SHIFTER_AMT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] value,
    input  logic [AMT_W-1:0]  shift_amount,
    output logic [DATA_W-1:0] shifted_value,
    output logic              out_valid
);

    localparam int unsigned STAGES = $clog2(DATA_W);

    logic [DATA_W-1:0] chain [0:STAGES];
    logic              out_of_range;
    logic [DATA_W-1:0] result_next;
    logic [DATA_W-1:0] shifted_value_reg;
    logic              out_valid_reg;

    assign chain[0] = value;

    // Stage gi shifts by 2**gi when amount bit gi is set.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            shifter_stage #(
                .DATA_W (DATA_W),
                .DIST   (1 << gi)
            ) u_stage (
                .sel     (shift_amount[gi]),
                .operand (chain[gi]),
                .result  (chain[gi+1])
            );
        end
    endgenerate

    assign out_of_range = amount_out_of_range(32'(shift_amount), STAGES);
    assign result_next  = out_of_range ? '0 : chain[STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            shifted_value_reg <= '0;
            out_valid_reg     <= 1'b0;
        end else if (in_valid) begin
            shifted_value_reg <= result_next;
            out_valid_reg     <= 1'b1;
        end else begin
            out_valid_reg     <= 1'b0;
        end
    end

    assign shifted_value = shifted_value_reg;
    assign out_valid     = out_valid_reg;

endmodule

// File: tb/tb_shifter.sv
// Directed and swept checks for the registered left barrel shifter.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_shifter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] value;
    logic [7:0]  shift_amount;
    logic [15:0] shifted_value;
    logic        out_valid;

    int vec_count  = 0;
    int miscompare = 0;

    shifter dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .value         (value),
        .shift_amount  (shift_amount),
        .shifted_value (shifted_value),
        .out_valid     (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompare++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    // One valid operation; in_valid is dropped after the capturing edge.
    task automatic apply_op(input logic [15:0] v, input logic [7:0] a);
        @(negedge clk);
        in_valid     = 1'b1;
        value        = v;
        shift_amount = a;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [15:0] v,
                            input logic [7:0] a, input logic [15:0] exp);
        apply_op(v, a);
        check_vec({tag, " value"}, 32'(shifted_value), 32'(exp));
        check_vec({tag, " valid"}, 32'(out_valid), 32'd1);
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] v, input logic [7:0] a);
        if (a >= 8'd16) return 16'h0000;
        return 16'((32'(v) << a) & 32'h0000_FFFF);
    endfunction

    initial begin
        logic [15:0] rv;
        reset        = 1'b1;
        in_valid     = 1'b0;
        value        = '0;
        shift_amount = '0;

        repeat (2) @(posedge clk);
        #1;
        check_vec("reset value", 32'(shifted_value), 32'h0);
        check_vec("reset valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        directed("zero<<2",    16'h0000, 8'd2,   16'h0000);
        directed("1<<2",       16'h0001, 8'd2,   16'h0004);
        directed("0x10<<3",    16'h0010, 8'd3,   16'h0080);
        directed("ones<<2",    16'hFFFF, 8'd2,   16'hFFFC);
        directed("2<<255",     16'h0002, 8'd255, 16'h0000);
        directed("8001<<16",   16'h8001, 8'd16,  16'h0000);
        directed("8001<<15",   16'h8001, 8'd15,  16'h8000);
        directed("abcd<<0",    16'hABCD, 8'd0,   16'hABCD);
        directed("ones<<7",    16'hFFFF, 8'd7,   16'hFF80);
        directed("8001<<17",   16'h8001, 8'd17,  16'h0000);
        directed("1234<<8",    16'h1234, 8'd8,   16'h3400);

        // Reset between edges must not disturb the held result.
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_vec("glitch reset value", 32'(shifted_value), 32'h3400);

        // Reset takes priority over a simultaneous valid operation.
        directed("pre-reset 1234<<4", 16'h1234, 8'd4, 16'h2340);
        @(negedge clk);
        reset        = 1'b1;
        in_valid     = 1'b1;
        value        = 16'hFFFF;
        shift_amount = 8'd1;
        @(posedge clk);
        #1;
        check_vec("mid reset value", 32'(shifted_value), 32'h0);
        check_vec("mid reset valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;

        directed("pre-hold 00f0<<4", 16'h00F0, 8'd4, 16'h0F00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_vec($sformatf("hold%0d value", i), 32'(shifted_value), 32'h0F00);
            check_vec($sformatf("hold%0d valid", i), 32'(out_valid), 32'd0);
        end

        for (int a = 0; a < 256; a++) begin
            rv = 16'($urandom);
            apply_op(rv, 8'(a));
            check_vec($sformatf("sweep %04h<<%0d", rv, a), 32'(shifted_value),
                      32'(ref_shift(rv, 8'(a))));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
        $finish;
    end

endmodule
